// File: rtl/apu_pulse_channel.sv
// NES APU pulse channel: register window decode, timer, duty sequencer, length, envelope and sweep.
// Define PULSE_SWEEP_EN to build the sweep unit; without it the period changes only through R2/R3 writes.
module apu_pulse_channel #(
  parameter logic [4:0] BASE_ADDR  = 5'h00,
  parameter int         CHANNEL_N  = 0,
  parameter int         MIN_PERIOD = 8,
  parameter int         OUT_W      = 4
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             cpu_clock,
  input  logic             apu_cs,
  input  logic [4:0]       ioreg_addr,
  input  logic [7:0]       ioreg_datain,
  input  logic             ioreg_wr,
  input  logic             en_pulse,
  input  logic             frame_l,
  input  logic             frame_e,
  output logic             lcounter_status,
  output logic [OUT_W-1:0] square_out
);

  localparam logic [10:0] MIN_P = 11'(MIN_PERIOD);

  logic             wr, wrR0, wrR2, wrR3, apuTick;
  logic             toggle_q, toggle_d;
  logic [1:0]       duty_q, duty_d;
  logic             halt_q, halt_d;
  logic             constVol_q, constVol_d;
  logic [3:0]       volPer_q, volPer_d;
  logic [10:0]      period_q, period_d;
  logic [10:0]      timer_q, timer_d;
  logic [2:0]       seq_q, seq_d;
  logic [7:0]       length_q, length_d;
  logic             envStart_q, envStart_d;
  logic [3:0]       envDiv_q, envDiv_d;
  logic [3:0]       decay_q, decay_d;
  logic [OUT_W-1:0] squareOut_q, squareOut_d;
  logic             dutyHigh, mute, gate;
  logic [3:0]       volume;

  function automatic logic [7:0] lengthLookup(input logic [4:0] idx);
    logic [7:0] len;
    case (idx)
      5'd0:  len = 8'd10;   5'd1:  len = 8'd254;  5'd2:  len = 8'd20;   5'd3:  len = 8'd2;
      5'd4:  len = 8'd40;   5'd5:  len = 8'd4;    5'd6:  len = 8'd80;   5'd7:  len = 8'd6;
      5'd8:  len = 8'd160;  5'd9:  len = 8'd8;    5'd10: len = 8'd60;   5'd11: len = 8'd10;
      5'd12: len = 8'd14;   5'd13: len = 8'd12;   5'd14: len = 8'd26;   5'd15: len = 8'd14;
      5'd16: len = 8'd12;   5'd17: len = 8'd16;   5'd18: len = 8'd24;   5'd19: len = 8'd18;
      5'd20: len = 8'd48;   5'd21: len = 8'd20;   5'd22: len = 8'd96;   5'd23: len = 8'd22;
      5'd24: len = 8'd192;  5'd25: len = 8'd24;   5'd26: len = 8'd72;   5'd27: len = 8'd26;
      5'd28: len = 8'd16;   5'd29: len = 8'd28;   5'd30: len = 8'd32;   default: len = 8'd30;
    endcase
    return len;
  endfunction

  assign wr      = apu_cs & ioreg_wr & cpu_clock & (ioreg_addr[4:2] == BASE_ADDR[4:2]);
  assign wrR0    = wr & (ioreg_addr[1:0] == 2'd0);
  assign wrR2    = wr & (ioreg_addr[1:0] == 2'd2);
  assign wrR3    = wr & (ioreg_addr[1:0] == 2'd3);
  assign apuTick = cpu_clock & toggle_q;

`ifdef PULSE_SWEEP_EN
  localparam logic [11:0] NEG_ADJ = (CHANNEL_N == 0) ? 12'd1 : 12'd0;

  logic        wrR1;
  logic        sweepEn_q, sweepEn_d;
  logic [2:0]  sweepPer_q, sweepPer_d;
  logic        sweepNeg_q, sweepNeg_d;
  logic [2:0]  sweepShift_q, sweepShift_d;
  logic [2:0]  sweepDiv_q, sweepDiv_d;
  logic        sweepReload_q, sweepReload_d;
  logic [11:0] shifted, target;

  assign wrR1    = wr & (ioreg_addr[1:0] == 2'd1);
  assign shifted = {1'b0, period_q} >> sweepShift_q;
  // Pulse 1 subtracts one extra (ones'-complement negate), pulse 2 does not.
  assign target  = sweepNeg_q ? ({1'b0, period_q} - shifted - NEG_ADJ)
                              : ({1'b0, period_q} + shifted);
  assign mute    = (period_q < MIN_P) | target[11];
`else
  assign mute    = (period_q < MIN_P);
`endif

  always_comb begin
    dutyHigh = 1'b0;
    case (duty_q)
      2'd0: dutyHigh = (seq_q == 3'd7);
      2'd1: dutyHigh = (seq_q[2:1] == 2'b11);
      2'd2: dutyHigh = seq_q[2];
      default: dutyHigh = (seq_q < 3'd6);
    endcase
  end

  assign volume          = constVol_q ? volPer_q : decay_q;
  assign gate            = dutyHigh & ~mute & (length_q != 8'd0) & en_pulse;
  assign lcounter_status = (length_q != 8'd0);
  assign square_out      = squareOut_q;

  // Frame-driven updates first, then register writes override them where both hit the same edge.
  always_comb begin
    toggle_d    = toggle_q;
    duty_d      = duty_q;
    halt_d      = halt_q;
    constVol_d  = constVol_q;
    volPer_d    = volPer_q;
    period_d    = period_q;
    timer_d     = timer_q;
    seq_d       = seq_q;
    length_d    = length_q;
    envStart_d  = envStart_q;
    envDiv_d    = envDiv_q;
    decay_d     = decay_q;
    squareOut_d = gate ? (OUT_W'(volume) << (OUT_W - 4)) : '0;
`ifdef PULSE_SWEEP_EN
    sweepEn_d     = sweepEn_q;
    sweepPer_d    = sweepPer_q;
    sweepNeg_d    = sweepNeg_q;
    sweepShift_d  = sweepShift_q;
    sweepDiv_d    = sweepDiv_q;
    sweepReload_d = sweepReload_q;

    if (frame_l) begin
      if ((sweepDiv_q == 3'd0) && sweepEn_q && (sweepShift_q != 3'd0) && !mute)
        period_d = target[10:0];
      if ((sweepDiv_q == 3'd0) || sweepReload_q) begin
        sweepDiv_d    = sweepPer_q;
        sweepReload_d = 1'b0;
      end else begin
        sweepDiv_d = sweepDiv_q - 3'd1;
      end
    end
`endif

    if (cpu_clock)
      toggle_d = ~toggle_q;

    if (apuTick) begin
      if (timer_q == 11'd0) begin
        timer_d = period_q;
        seq_d   = seq_q + 3'd1;
      end else begin
        timer_d = timer_q - 11'd1;
      end
    end

    if (frame_l && (length_q != 8'd0) && !halt_q)
      length_d = length_q - 8'd1;

    if (frame_e) begin
      if (envStart_q) begin
        envStart_d = 1'b0;
        decay_d    = 4'd15;
        envDiv_d   = volPer_q;
      end else if (envDiv_q == 4'd0) begin
        envDiv_d = volPer_q;
        if (decay_q != 4'd0)
          decay_d = decay_q - 4'd1;
        else if (halt_q)
          decay_d = 4'd15;
      end else begin
        envDiv_d = envDiv_q - 4'd1;
      end
    end

    if (wrR0) begin
      duty_d     = ioreg_datain[7:6];
      halt_d     = ioreg_datain[5];
      constVol_d = ioreg_datain[4];
      volPer_d   = ioreg_datain[3:0];
    end
`ifdef PULSE_SWEEP_EN
    if (wrR1) begin
      sweepEn_d     = ioreg_datain[7];
      sweepPer_d    = ioreg_datain[6:4];
      sweepNeg_d    = ioreg_datain[3];
      sweepShift_d  = ioreg_datain[2:0];
      sweepReload_d = 1'b1;
    end
`endif
    if (wrR2)
      period_d = {period_q[10:8], ioreg_datain};
    if (wrR3) begin
      period_d   = {ioreg_datain[2:0], period_q[7:0]};
      seq_d      = 3'd0;
      envStart_d = 1'b1;
      if (en_pulse)
        length_d = lengthLookup(ioreg_datain[7:3]);
    end

    if (!en_pulse)
      length_d = 8'd0;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      toggle_q    <= 1'b0;
      duty_q      <= 2'd0;
      halt_q      <= 1'b0;
      constVol_q  <= 1'b0;
      volPer_q    <= 4'd0;
      period_q    <= 11'd0;
      timer_q     <= 11'd0;
      seq_q       <= 3'd0;
      length_q    <= 8'd0;
      envStart_q  <= 1'b0;
      envDiv_q    <= 4'd0;
      decay_q     <= 4'd0;
      squareOut_q <= '0;
    end else begin
      toggle_q    <= toggle_d;
      duty_q      <= duty_d;
      halt_q      <= halt_d;
      constVol_q  <= constVol_d;
      volPer_q    <= volPer_d;
      period_q    <= period_d;
      timer_q     <= timer_d;
      seq_q       <= seq_d;
      length_q    <= length_d;
      envStart_q  <= envStart_d;
      envDiv_q    <= envDiv_d;
      decay_q     <= decay_d;
      squareOut_q <= squareOut_d;
    end
  end

`ifdef PULSE_SWEEP_EN
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sweepEn_q     <= 1'b0;
      sweepPer_q    <= 3'd0;
      sweepNeg_q    <= 1'b0;
      sweepShift_q  <= 3'd0;
      sweepDiv_q    <= 3'd0;
      sweepReload_q <= 1'b0;
    end else begin
      sweepEn_q     <= sweepEn_d;
      sweepPer_q    <= sweepPer_d;
      sweepNeg_q    <= sweepNeg_d;
      sweepShift_q  <= sweepShift_d;
      sweepDiv_q    <= sweepDiv_d;
      sweepReload_q <= sweepReload_d;
    end
  end
`endif

endmodule

// File: tb/tb_apu_pulse_channel.sv
// Directed bench for apu_pulse_channel: two voices on a shared bus (pulse 1 at 0x00, pulse 2 at 0x04, 6-bit out).
module tb_apu_pulse_channel;

  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_clock = 1'b0;
  logic       apu_cs = 1'b0;
  logic [4:0] ioreg_addr = 5'd0;
  logic [7:0] ioreg_datain = 8'd0;
  logic       ioreg_wr = 1'b0;
  logic       en_pulse = 1'b0;
  logic       frame_l = 1'b0;
  logic       frame_e = 1'b0;
  logic       status0, status1;
  logic [3:0] out0;
  logic [5:0] out1;

  int nChecks = 0;
  int nPass = 0;

  always #5 sysclk = ~sysclk;

  apu_pulse_channel #(.BASE_ADDR(5'h00), .CHANNEL_N(0), .MIN_PERIOD(8), .OUT_W(4)) dut0 (
    .sysclk(sysclk), .reset(reset), .cpu_clock(cpu_clock), .apu_cs(apu_cs),
    .ioreg_addr(ioreg_addr), .ioreg_datain(ioreg_datain), .ioreg_wr(ioreg_wr),
    .en_pulse(en_pulse), .frame_l(frame_l), .frame_e(frame_e),
    .lcounter_status(status0), .square_out(out0)
  );

  apu_pulse_channel #(.BASE_ADDR(5'h04), .CHANNEL_N(1), .MIN_PERIOD(8), .OUT_W(6)) dut1 (
    .sysclk(sysclk), .reset(reset), .cpu_clock(cpu_clock), .apu_cs(apu_cs),
    .ioreg_addr(ioreg_addr), .ioreg_datain(ioreg_datain), .ioreg_wr(ioreg_wr),
    .en_pulse(en_pulse), .frame_l(frame_l), .frame_e(frame_e),
    .lcounter_status(status1), .square_out(out1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [4:0] a, input logic [7:0] d, input logic fl);
    @(negedge sysclk);
    apu_cs = 1'b1; ioreg_wr = 1'b1; cpu_clock = 1'b1; ioreg_addr = a; ioreg_datain = d; frame_l = fl;
    @(negedge sysclk);
    apu_cs = 1'b0; ioreg_wr = 1'b0; cpu_clock = 1'b0; frame_l = 1'b0;
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [7:0] d);
    applyStimulus(a, d, 1'b0);
  endtask

  task automatic pulseFrameL();
    @(negedge sysclk); frame_l = 1'b1;
    @(negedge sysclk); frame_l = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic pulseFrameE(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk); frame_e = 1'b1;
      @(negedge sysclk); frame_e = 1'b0;
    end
    @(negedge sysclk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    en_pulse = 1'b1;
    repeat (3) @(negedge sysclk);
    checkOutput("reset_out0", 32'(out0), 32'd0);
    checkOutput("reset_status0", 32'(status0), 32'd0);
    checkOutput("reset_out1", 32'(out1), 32'd0);
    reset = 1'b1;
    @(negedge sysclk);

    // Duty 2 tone, period 0xFF, halted length 254
    writeReg(5'd0, 8'hBF);
    writeReg(5'd2, 8'hFF);
    writeReg(5'd3, 8'h08);
    checkOutput("tone_status", 32'(status0), 32'd1);
    cpu_clock = 1'b1;
    cnt = 0;
    while (out0 !== 4'd15 && cnt < 6000) begin @(negedge sysclk); cnt++; end
    checkOutput("tone_first_high_cycles", 32'(cnt), 32'd1538);
    cnt = 0;
    while (out0 === 4'd15 && cnt < 6000) begin @(negedge sysclk); cnt++; end
    checkOutput("tone_high_cycles", 32'(cnt), 32'd2048);
    checkOutput("tone_low_value", 32'(out0), 32'd0);
    cnt = 0;
    while (out0 !== 4'd15 && cnt < 6000) begin @(negedge sysclk); cnt++; end
    checkOutput("tone_low_cycles", 32'(cnt), 32'd2048);
    cpu_clock = 1'b0;
    pulseFrameL();
    checkOutput("tone_halt_status", 32'(status0), 32'd1);

    // Second voice window is untouched by the first voice's writes, then plays scaled
    checkOutput("v2_idle_out", 32'(out1), 32'd0);
    checkOutput("v2_idle_status", 32'(status1), 32'd0);
    writeReg(5'd4, 8'hDF);
    writeReg(5'd6, 8'h00);
    writeReg(5'd7, 8'h01);
    @(negedge sysclk);
    checkOutput("v2_scaled_out", 32'(out1), 32'd60);
    checkOutput("v2_status", 32'(status1), 32'd1);

    // Length expiry, load-wins, enable clear
    writeReg(5'd0, 8'h10);
    writeReg(5'd3, 8'h18);
    checkOutput("len_loaded", 32'(status0), 32'd1);
    pulseFrameL();
    checkOutput("len_after_1", 32'(status0), 32'd1);
    pulseFrameL();
    checkOutput("len_after_2", 32'(status0), 32'd0);
    checkOutput("len_out", 32'(out0), 32'd0);
    applyStimulus(5'd3, 8'h18, 1'b1);
    checkOutput("len_load_wins", 32'(status0), 32'd1);
    pulseFrameL();
    checkOutput("len_load_wins_1", 32'(status0), 32'd1);
    pulseFrameL();
    checkOutput("len_load_wins_2", 32'(status0), 32'd0);
    writeReg(5'd3, 8'h08);
    checkOutput("len_reload", 32'(status0), 32'd1);
    en_pulse = 1'b0;
    @(negedge sysclk);
    checkOutput("len_en_clear", 32'(status0), 32'd0);
    writeReg(5'd3, 8'h08);
    checkOutput("len_en_block", 32'(status0), 32'd0);
    en_pulse = 1'b1;

    // Envelope, period 2, duty 3
    writeReg(5'd0, 8'hC2);
    writeReg(5'd3, 8'h08);
    pulseFrameE(1);
    checkOutput("env_1", 32'(out0), 32'd15);
    pulseFrameE(2);
    checkOutput("env_3", 32'(out0), 32'd15);
    pulseFrameE(1);
    checkOutput("env_4", 32'(out0), 32'd14);
    pulseFrameE(41);
    checkOutput("env_45", 32'(out0), 32'd1);
    pulseFrameE(1);
    checkOutput("env_46", 32'(out0), 32'd0);
    pulseFrameE(6);
    checkOutput("env_hold_52", 32'(out0), 32'd0);
    writeReg(5'd0, 8'hE2);
    pulseFrameE(2);
    checkOutput("env_loop_54", 32'(out0), 32'd0);
    pulseFrameE(1);
    checkOutput("env_loop_55", 32'(out0), 32'd15);

    // Minimum-period mute boundary
    writeReg(5'd0, 8'hFF);
    writeReg(5'd1, 8'h00);
    writeReg(5'd2, 8'h05);
    writeReg(5'd3, 8'h08);
    @(negedge sysclk);
    checkOutput("min_mute_5", 32'(out0), 32'd0);
    writeReg(5'd2, 8'h08);
    @(negedge sysclk);
    checkOutput("min_play_8", 32'(out0), 32'd15);
    writeReg(5'd2, 8'h07);
    @(negedge sysclk);
    checkOutput("min_mute_7", 32'(out0), 32'd0);

`ifdef PULSE_SWEEP_EN
    writeReg(5'd2, 8'h00);
    writeReg(5'd3, 8'h09);
    writeReg(5'd1, 8'h81);
    pulseFrameL();
    checkOutput("sweep_add", 32'(dut0.period_q), 32'h180);
    writeReg(5'd2, 8'h00);
    writeReg(5'd3, 8'h09);
    writeReg(5'd1, 8'h89);
    writeReg(5'd6, 8'h00);
    writeReg(5'd7, 8'h09);
    writeReg(5'd5, 8'h89);
    pulseFrameL();
    checkOutput("sweep_neg_ch0", 32'(dut0.period_q), 32'h07F);
    checkOutput("sweep_neg_ch1", 32'(dut1.period_q), 32'h080);
    writeReg(5'd1, 8'h01);
    writeReg(5'd2, 8'h00);
    writeReg(5'd3, 8'h0E);
    @(negedge sysclk);
    checkOutput("sweep_overflow_mute", 32'(out0), 32'd0);
`else
    writeReg(5'd2, 8'h00);
    writeReg(5'd3, 8'h0E);
    @(negedge sysclk);
    checkOutput("nosweep_0x600_plays", 32'(out0), 32'd15);
`endif

    // Reset mid-tone
    writeReg(5'd0, 8'hFF);
    writeReg(5'd1, 8'h00);
    writeReg(5'd2, 8'h00);
    writeReg(5'd3, 8'h09);
    @(negedge sysclk);
    checkOutput("pre_reset_out", 32'(out0), 32'd15);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_mid_out0", 32'(out0), 32'd0);
    checkOutput("reset_mid_status0", 32'(status0), 32'd0);
    checkOutput("reset_mid_out1", 32'(out1), 32'd0);
    checkOutput("reset_mid_status1", 32'(status1), 32'd0);
    @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    checkOutput("post_reset_out0", 32'(out0), 32'd0);
    checkOutput("post_reset_status0", 32'(status0), 32'd0);
    checkOutput("post_reset_period0", 32'(dut0.period_q), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
